// File: rtl/hex_display_scanner.sv
// Four-digit multiplexed hex display driver with frame-aligned shadow latch and halt blink.
// Optional leading-zero blanking is enabled by defining HEX_DISPLAY_LEADING_ZERO_BLANK_EN.
module hex_display_scanner #(
  parameter int CLK_DIV        = 50000,
  parameter int BLINK_TICKS    = 256,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] value,
  input  logic        run,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        dp
);

  localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [PW-1:0] PRE_MAX   = PW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_TICKS - 1);
  localparam logic          POL       = (SEG_ACTIVE_LOW != 0);

  logic [PW-1:0] prescaler;
  logic [1:0]    digitIdx;
  logic [15:0]   shadow;
  logic [BW-1:0] blinkCnt;
  logic          blankPhase;
  logic          loadPending;
  logic          tick;

  logic [3:0]    nibbleP0;
  logic          leadBlankP0;
  logic          digitOnP0;
  logic [6:0]    segP0;
  logic [3:0]    anP0;
  logic          dpP0;

  function automatic logic [6:0] hexDecode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
      4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
      4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
      4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
    endcase
    return s;
  endfunction

  function automatic logic [6:0] segDrive(input logic [6:0] litSegs);
    return litSegs ^ {7{POL}};
  endfunction

  assign tick = (prescaler == PRE_MAX);

  // Scan timing, frame-aligned shadow latch and halt blink state
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prescaler   <= '0;
      digitIdx    <= 2'd0;
      shadow      <= 16'h0000;
      blinkCnt    <= '0;
      blankPhase  <= 1'b0;
      loadPending <= 1'b1;
    end else begin
      prescaler   <= tick ? '0 : prescaler + 1'b1;
      loadPending <= 1'b0;
      if (tick) digitIdx <= digitIdx + 2'd1;
      if (loadPending || (tick && digitIdx == 2'd3)) shadow <= value;
      if (run) begin
        blinkCnt   <= '0;
        blankPhase <= 1'b0;
      end else if (tick) begin
        if (blinkCnt == BLINK_MAX) begin
          blinkCnt   <= '0;
          blankPhase <= ~blankPhase;
        end else begin
          blinkCnt <= blinkCnt + 1'b1;
        end
      end
    end
  end

  // Stage p0: decode the active digit from current scan state
  always_comb begin
    nibbleP0    = 4'(shadow >> {digitIdx, 2'b00});
    leadBlankP0 = 1'b0;
`ifdef HEX_DISPLAY_LEADING_ZERO_BLANK_EN
    case (digitIdx)
      2'd1:    leadBlankP0 = (shadow[15:4]  == 12'h000);
      2'd2:    leadBlankP0 = (shadow[15:8]  == 8'h00);
      2'd3:    leadBlankP0 = (shadow[15:12] == 4'h0);
      default: leadBlankP0 = 1'b0;
    endcase
`endif
    // run overrides a stale blank phase so restarting is visible immediately
    digitOnP0 = (run || !blankPhase) && !leadBlankP0;
    anP0      = digitOnP0 ? ~(4'b0001 << digitIdx) : 4'hF;
    segP0     = digitOnP0 ? segDrive(hexDecode(nibbleP0)) : segDrive(7'h00);
    dpP0      = (run && digitIdx == 2'd0) ^ POL;
  end

  // Stage p1: registered display drive
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      an  <= 4'hF;
      seg <= segDrive(7'h00);
      dp  <= POL;
    end else begin
      an  <= anP0;
      seg <= segP0;
      dp  <= dpP0;
    end
  end

endmodule

// File: doc/hex_display_scanner.md
Name: hex_display_scanner

Overview:
- Downstream display stage for the CPU's 16-bit hex display output and run indicator.
- Time-multiplexes the 16-bit value onto a 4-digit common-anode seven-segment display, one hex nibble per digit.
- Latches the value only at frame boundaries, so digits never tear while the CPU updates the output.
- Blinks the display while the CPU is halted and drives a run-indicator decimal point.

Parameters:
- CLK_DIV, 50000: clock cycles per digit slot. Legal range is 2 or more.
- BLINK_TICKS, 256: scan ticks per blink half-period while halted. Legal range is 1 or more.
- SEG_ACTIVE_LOW, 1: when 1, the seg and dp outputs are active-low; when 0, they are active-high. The an output is always active-low.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- value  in  16  hex value from the CPU display output. Bits [3:0] go to digit 0 (rightmost).
- run  in  1  CPU run indicator: 1 = running, 0 = halted.
- seg  out  7  segment drive, {g,f,e,d,c,b,a}.
- an  out  4  digit enables, one-hot active-low; an[i] selects digit i.
- dp  out  1  decimal point drive.

Behaviour:
Reset (asserted asynchronously):
- an = 4'b1111; seg and dp = off (all 1s if SEG_ACTIVE_LOW=1, all 0s otherwise).
- prescaler = 0, digit index = 0, shadow = 16'h0000, blink counter = 0, blink phase = visible, load_pending = 1.

Prescaler:
- Counts 0..CLK_DIV-1 and wraps.
- tick = 1 for exactly one cycle, when the count equals CLK_DIV-1.

Digit index:
- 2-bit counter, 0→1→2→3→0. Advances only on tick.

Shadow register:
- Loads value on the first clock edge after reset deassertion (load_pending = 1, then cleared).
- Thereafter loads value only on a tick where digit index = 3, i.e. at the end of a frame.
- value changes at any other time have no effect until the next frame boundary.

Outputs:
- seg, an and dp are registered and update every cycle from the current digit index, shadow, run and blink phase.
- Latency from a digit-index change to the new an/seg is 1 cycle.
- Active digit i: an[i] = 0, all other an bits = 1. seg = hex decode of shadow[4i+3:4i].

Hex decode (active-high, {g..a}):
- 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
- 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
- Output is inverted when SEG_ACTIVE_LOW=1.

dp:
- Lit only when digit index = 0 and run = 1; off otherwise.

Blink:
- run = 1: blink counter is held at 0 and blink phase is held at visible.
- run = 0: blink counter increments on each tick. On reaching BLINK_TICKS-1 it wraps to 0 and blink phase toggles.
- Blank phase: an = 4'b1111 and seg = off. The scan continues internally and shadow loads proceed normally.
- run rising mid-blank: the display is visible again on the next cycle.

Simultaneous events: reset dominates everything. tick with digit index = 3 loads shadow and wraps the index in the same cycle. Shadow load and blink toggle are independent.

Reset asserted mid-frame: all state returns to reset values immediately, without waiting for a clock edge.

Optional Feature:
Macro: HEX_DISPLAY_LEADING_ZERO_BLANK_EN
- Defined: digits 3, 2 and 1 are blanked (their an bit held at 1) when that nibble and every higher nibble of shadow are 0. Digit 0 is always shown. Example: shadow 16'h0000 lights digit 0 only, showing "0"; 16'h00A0 shows digits 1 and 0.
- Not defined: all four digits are always shown, including leading zeros.

Test Plan:
All scenarios use CLK_DIV=4, BLINK_TICKS=2, SEG_ACTIVE_LOW=1, macro undefined unless stated.

1. Reset and first load: hold reset 3 cycles with value=16'h1234, release → an=1111 during reset; after release, digit 0 shows seg=7'h19 ("4") with an=1110 and dp=0 (run=1). Digit 3 then shows seg=7'h79 ("1").
2. Scan order: run 40 cycles → an sequence 1110, 1101, 1011, 0111, repeating, each held exactly 4 cycles. dp is lit only in the 1110 slots.
3. Tear-free update: change value to 16'hABCD while digit 1 is active → digits 1–3 keep showing 1234 data until the frame ends. The next frame shows D, C, b, A (seg 21, 46, 03, 08).
4. Halt blink: drop run to 0 → an/seg visible for 2 ticks, then blank (an=1111, seg=7F) for 2 ticks, alternating. dp=1 (off) throughout. Raising run → visible on the next cycle.
5. Async reset mid-frame: assert reset between clock edges while digit 2 is active → an=1111 immediately, before the next clock edge. After release, scanning restarts at digit 0.
6. With the macro defined and value=16'h0005 → only an=1110 is ever driven low; digits 1–3 stay 1 for a full frame.
